// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the datapath ALU: captures one RV32I instruction,
// decodes ALU controls, samples the ALU result/flags and reports write-back status.
module alu_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTR,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [3:0]        ALUSel,
  output logic [1:0]        A_SEL,
  output logic              B_SEL,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              ZERO_FLAG,
  input  logic              NEG_FLAG,
  output logic [DATA_W-1:0] RESULT,
  output logic              REG_WEN,
  output logic              BR_TAKEN,
  output logic              ILLEGAL,
  output logic              DONE
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  // taken_nz: branch is taken when the ALU result is non-zero (else when zero)
  typedef struct packed {
    logic       legal;
    logic [3:0] op;
    logic [1:0] asel;
    logic       bsel;
    logic       wen;
    logic       br;
    logic       taken_nz;
  } dec_t;

  function automatic logic [3:0] f3_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (opc)
      7'b0110011: begin
        d.wen = 1'b1;
        d.op  = f3_op(f3);
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      d.op = OP_SUB;
          else if (f3 == 3'b101) d.op = OP_SRA;
          else                   d.legal = 1'b0;
        end else if (f7 != F7_BASE) begin
          d.legal = 1'b0;
        end
      end
      7'b0010011: begin
        d.wen  = 1'b1;
        d.bsel = 1'b1;
        d.op   = f3_op(f3);
        if (f3 == 3'b001 && f7 != F7_BASE) d.legal = 1'b0;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)        d.op = OP_SRA;
          else if (f7 != F7_BASE)  d.legal = 1'b0;
        end
      end
      7'b0110111: begin
        d.wen  = 1'b1;
        d.bsel = 1'b1;
        d.asel = 2'd2;
      end
      7'b0010111: begin
        d.wen  = 1'b1;
        d.bsel = 1'b1;
        d.asel = 2'd1;
      end
      7'b1100011: begin
        d.br = 1'b1;
        case (f3)
          3'b000:  d.op = OP_SUB;
          3'b001:  begin d.op = OP_SUB;  d.taken_nz = 1'b1; end
          3'b100:  begin d.op = OP_SLT;  d.taken_nz = 1'b1; end
          3'b101:  d.op = OP_SLT;
          3'b110:  begin d.op = OP_SLTU; d.taken_nz = 1'b1; end
          3'b111:  d.op = OP_SLTU;
          default: d.legal = 1'b0;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d = '0;
    return d;
  endfunction

  state_t            state;
  logic [6:0]        opc_r;
  logic [2:0]        f3_r;
  logic [6:0]        f7_r;
  dec_t              dec;
  logic [3:0]        alusel_r;
  logic [1:0]        asel_r;
  logic              bsel_r;
  logic              wen_r;
  logic              br_r;
  logic              nz_r;
  logic              zero_r;
  logic              ill_r;
  logic              done_r;
  logic [DATA_W-1:0] res_r;
  logic              unused_bits;

  assign dec         = decode(opc_r, f3_r, f7_r);
  assign unused_bits = ^{NEG_FLAG, INSTR[24:15], INSTR[11:7]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      alusel_r <= '0;
      asel_r   <= '0;
      bsel_r   <= 1'b0;
      wen_r    <= 1'b0;
      br_r     <= 1'b0;
      ill_r    <= 1'b0;
      done_r   <= 1'b0;
      res_r    <= '0;
    end else begin
      case (state)
        IDLE: if (INSTR_VALID) state <= DECODE;
        DECODE: begin
          alusel_r <= dec.op;
          asel_r   <= dec.asel;
          bsel_r   <= dec.bsel;
          wen_r    <= dec.wen;
          br_r     <= dec.br;
          if (dec.legal) begin
            state <= EXEC;
          end else begin
            ill_r  <= 1'b1;
            done_r <= 1'b1;
            state  <= WB;
          end
        end
        EXEC: begin
          res_r  <= ALU_OUT;
          done_r <= 1'b1;
          state  <= WB;
        end
        default: begin
          alusel_r <= '0;
          asel_r   <= '0;
          bsel_r   <= 1'b0;
          wen_r    <= 1'b0;
          br_r     <= 1'b0;
          ill_r    <= 1'b0;
          done_r   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Instruction fields and flag snapshot carry no reset; control above gates their use
  always_ff @(posedge CLK) begin
    if (state == IDLE && INSTR_VALID) begin
      opc_r <= INSTR[6:0];
      f3_r  <= INSTR[14:12];
      f7_r  <= INSTR[31:25];
    end
    if (state == DECODE) nz_r   <= dec.taken_nz;
    if (state == EXEC)   zero_r <= ZERO_FLAG;
  end

  assign INSTR_READY = (state == IDLE) & ~RESET;
  assign ALUSel      = RESET ? 4'd0 : alusel_r;
  assign A_SEL       = RESET ? 2'd0 : asel_r;
  assign B_SEL       = bsel_r & ~RESET;
  assign RESULT      = RESET ? '0 : res_r;
  assign DONE        = done_r & ~RESET;
  assign REG_WEN     = done_r & wen_r & ~RESET;
  assign BR_TAKEN    = done_r & br_r & (zero_r ^ nz_r) & ~RESET;
  assign ILLEGAL     = done_r & ill_r & ~RESET;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level model checked every cycle, plus
// directed instructions with hand-computed results.
module tb_alu_issue_ctrl;
  localparam int DATA_W = 32;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [3:0]  ALUSel;
  logic [1:0]  A_SEL;
  logic        B_SEL;
  logic [31:0] ALU_OUT;
  logic        ZERO_FLAG;
  logic        NEG_FLAG;
  logic [31:0] RESULT;
  logic        REG_WEN;
  logic        BR_TAKEN;
  logic        ILLEGAL;
  logic        DONE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_issue_ctrl #(.DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALUSel(ALUSel), .A_SEL(A_SEL), .B_SEL(B_SEL),
    .ALU_OUT(ALU_OUT), .ZERO_FLAG(ZERO_FLAG), .NEG_FLAG(NEG_FLAG),
    .RESULT(RESULT), .REG_WEN(REG_WEN), .BR_TAKEN(BR_TAKEN),
    .ILLEGAL(ILLEGAL), .DONE(DONE)
  );

  // Combinational ALU driven by the controller's selects
  logic [31:0] rs1v, rs2v, immv, pcv, opa, opb, alu;
  always_comb begin
    alu = '0;
    opa = (A_SEL == 2'd0) ? rs1v : (A_SEL == 2'd1) ? pcv : 32'd0;
    opb = B_SEL ? immv : rs2v;
    case (ALUSel)
      4'd0: alu = opa + opb;
      4'd1: alu = opa - opb;
      4'd2: alu = opa << opb[4:0];
      4'd3: alu = {31'd0, $signed(opa) < $signed(opb)};
      4'd4: alu = {31'd0, opa < opb};
      4'd5: alu = opa ^ opb;
      4'd6: alu = opa >> opb[4:0];
      4'd7: alu = $signed(opa) >>> opb[4:0];
      4'd8: alu = opa | opb;
      4'd9: alu = opa & opb;
      default: alu = '0;
    endcase
  end
  assign ALU_OUT   = alu;
  assign ZERO_FLAG = (alu == 32'd0);
  assign NEG_FLAG  = alu[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of an instruction word
  task automatic mdec(input logic [31:0] ins, output bit legal, output logic [3:0] op,
                      output logic [1:0] asel, output bit bsel, output bit wen, output bit br);
    logic [3:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    base  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc   = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    legal = 1; op = 0; asel = 0; bsel = 0; wen = 0; br = 0;
    if (opc == 7'h33) begin
      wen = 1;
      if (f7 == 7'h00) op = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 4'd7;
      else legal = 0;
    end else if (opc == 7'h13) begin
      wen = 1; bsel = 1;
      if (f3 == 3'd1) begin op = 4'd2; legal = (f7 == 7'h00); end
      else if (f3 == 3'd5) begin
        if (f7 == 7'h00) op = 4'd6;
        else if (f7 == 7'h20) op = 4'd7;
        else legal = 0;
      end else op = base[f3];
    end else if (opc == 7'h37) begin
      wen = 1; bsel = 1; asel = 2'd2;
    end else if (opc == 7'h17) begin
      wen = 1; bsel = 1; asel = 2'd1;
    end else if (opc == 7'h63) begin
      br = 1;
      if (f3 == 3'd0 || f3 == 3'd1) op = 4'd1;
      else if (f3 == 3'd4 || f3 == 3'd5) op = 4'd3;
      else if (f3 == 3'd6 || f3 == 3'd7) op = 4'd4;
      else legal = 0;
    end else legal = 0;
    if (!legal) begin op = 0; asel = 0; bsel = 0; wen = 0; br = 0; end
  endtask

  // Model: one instruction in flight, phase 1 decode, 2 exec, 3 write-back (illegal: 2 is write-back)
  bit          started = 0, inflight = 0, m_legal, m_bsel, m_wen, m_br, m_zr;
  logic [3:0]  m_op;
  logic [1:0]  m_asel;
  logic [2:0]  m_f3;
  logic [31:0] m_res = '0;
  int          k, wbk;
  logic        s_reset, s_valid, s_zero;
  logic [31:0] s_instr, s_alu;

  initial begin
    bit e_done, e_taken;
    forever begin
      @(negedge CLK); #4;
      s_reset = RESET; s_valid = INSTR_VALID; s_instr = INSTR; s_alu = ALU_OUT; s_zero = ZERO_FLAG;
      @(posedge CLK);
      if (s_reset) begin
        started = 1; inflight = 0; m_res = '0;
      end else if (started && inflight) begin
        if (m_legal && k == 2) begin m_res = s_alu; m_zr = s_zero; end
        if (k == wbk) inflight = 0;
        else k++;
      end else if (started && s_valid) begin
        mdec(s_instr, m_legal, m_op, m_asel, m_bsel, m_wen, m_br);
        m_f3 = s_instr[14:12];
        inflight = 1; k = 1; wbk = m_legal ? 3 : 2;
      end
      #1;
      if (started) begin
        e_done  = inflight && k == wbk;
        e_taken = (m_f3 == 3'd0 || m_f3 == 3'd5 || m_f3 == 3'd7) ? m_zr : !m_zr;
        chk("ready",  32'(INSTR_READY), 32'(!s_reset && !inflight));
        chk("alusel", 32'(ALUSel),  32'((inflight && k >= 2) ? m_op : 4'd0));
        chk("a_sel",  32'(A_SEL),   32'((inflight && k >= 2) ? m_asel : 2'd0));
        chk("b_sel",  32'(B_SEL),   32'(inflight && k >= 2 && m_bsel));
        chk("result", RESULT,       m_res);
        chk("done",   32'(DONE),    32'(e_done));
        chk("reg_wen", 32'(REG_WEN), 32'(e_done && m_wen));
        chk("br_taken", 32'(BR_TAKEN), 32'(e_done && m_br && e_taken));
        chk("illegal", 32'(ILLEGAL), 32'(e_done && !m_legal));
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    @(negedge CLK);
    while (!INSTR_READY && w < 20) begin @(negedge CLK); w++; end
    chk("ready_wait", 32'(INSTR_READY), 32'd1);
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, output int lat, output logic [3:0] xop,
                     output logic [1:0] xa, output logic xb, output logic [31:0] xres,
                     output logic xwen, output logic xbr, output logic xill);
    lat = -1; xop = 'x; xa = 'x; xb = 'x; xres = 'x; xwen = 'x; xbr = 'x; xill = 'x;
    wait_ready();
    INSTR = ins; rs1v = a; rs2v = b; immv = im; INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge CLK); #2;
      if (c == 2) begin xop = ALUSel; xa = A_SEL; xb = B_SEL; end
      if (DONE) begin
        lat = c; xres = RESULT; xwen = REG_WEN; xbr = BR_TAKEN; xill = ILLEGAL;
        break;
      end
    end
  endtask

  initial begin
    int          lat, ndone, first, last;
    logic [3:0]  xop;
    logic [1:0]  xa;
    logic        xb, xwen, xbr, xill;
    logic [31:0] xres;

    RESET = 1'b1; INSTR_VALID = 1'b1; INSTR = 32'h00508093;
    rs1v = 0; rs2v = 0; immv = 0; pcv = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #2;
      chk("rst_ready", 32'(INSTR_READY), 32'd0);
      chk("rst_done",  32'(DONE), 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b0; INSTR_VALID = 1'b0;
    @(posedge CLK); #2;
    chk("rst_release_ready", 32'(INSTR_READY), 32'd1);

    // sub x0,x1,x2 with 7 - 3
    run(32'h40208033, 32'd7, 32'd3, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("sub_lat", 32'(lat), 32'd3);
    chk("sub_op", 32'(xop), 32'd1);
    chk("sub_a", 32'(xa), 32'd0);
    chk("sub_b", 32'(xb), 32'd0);
    chk("sub_res", xres, 32'd4);
    chk("sub_wen", 32'(xwen), 32'd1);
    chk("sub_br", 32'(xbr), 32'd0);
    chk("sub_ill", 32'(xill), 32'd0);

    // blt x1,x2 with -5 < 3
    run(32'h0020C063, 32'hFFFFFFFB, 32'd3, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("blt_op", 32'(xop), 32'd3);
    chk("blt_br", 32'(xbr), 32'd1);
    chk("blt_wen", 32'(xwen), 32'd0);

    // bgeu x1,x2 with 2 < 5 unsigned
    run(32'h0020F063, 32'd2, 32'd5, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("bgeu_op", 32'(xop), 32'd4);
    chk("bgeu_br", 32'(xbr), 32'd0);

    // beq x1,x2 with equal operands
    run(32'h00208063, 32'd9, 32'd9, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("beq_op", 32'(xop), 32'd1);
    chk("beq_br", 32'(xbr), 32'd1);

    // lui x1,0x12345
    run(32'h123450B7, 32'd0, 32'd0, 32'h12345000, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("lui_a", 32'(xa), 32'd2);
    chk("lui_b", 32'(xb), 32'd1);
    chk("lui_op", 32'(xop), 32'd0);
    chk("lui_res", xres, 32'h12345000);
    chk("lui_wen", 32'(xwen), 32'd1);

    // opcode 0x7F: early write-back, result untouched
    run(32'h0000007F, 32'd1, 32'd1, 32'd1, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("ill_lat", 32'(lat), 32'd2);
    chk("ill_flag", 32'(xill), 32'd1);
    chk("ill_wen", 32'(xwen), 32'd0);
    chk("ill_res", xres, 32'h12345000);

    // auipc x1,0x1 at pc 0x1000
    run(32'h00001097, 32'd0, 32'd0, 32'h1000, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("auipc_a", 32'(xa), 32'd1);
    chk("auipc_res", xres, 32'h2000);

    // R-type funct7=0100000 with funct3=100
    run(32'h4020C033, 32'd1, 32'd2, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("rill_flag", 32'(xill), 32'd1);
    chk("rill_lat", 32'(lat), 32'd2);

    // srai x1,x1,5 on 0x80000000
    run(32'h4050D093, 32'h80000000, 32'd0, 32'd5, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("srai_op", 32'(xop), 32'd7);
    chk("srai_res", xres, 32'hFC000000);

    // branch funct3=010 is not a branch
    run(32'h0020A063, 32'd1, 32'd2, 32'd0, lat, xop, xa, xb, xres, xwen, xbr, xill);
    chk("bill_flag", 32'(xill), 32'd1);
    chk("bill_br", 32'(xbr), 32'd0);

    // valid held for 12 cycles
    wait_ready();
    INSTR = 32'h00508093; rs1v = 32'd1; immv = 32'd5; INSTR_VALID = 1'b1;
    ndone = 0; first = -1; last = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge CLK); #2;
      if (DONE) begin
        ndone++;
        if (first < 0) first = c;
        last = c;
      end
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("thr_dones", 32'(ndone), 32'd3);
    chk("thr_first", 32'(first), 32'd3);
    chk("thr_last", 32'(last), 32'd11);

    // reset while executing
    wait_ready();
    INSTR = 32'h00508093; INSTR_VALID = 1'b1;
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #2;
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #2;
    chk("midrst_ready", 32'(INSTR_READY), 32'd1);
    chk("midrst_done2", 32'(DONE), 32'd0);

    repeat (3) @(posedge CLK);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
